// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - shared types and constants for the MIDI message transmitter
//
// Purpose : FSM state encoding, frame geometry and the default bit timing
//           used by midi_msg_tx and midi_baud_tick.
// Ports   : none (package)

package midi_pkg;

  // Serial frame: 1 start bit, 8 data bits, 1 stop bit.
  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = FRAME_BITS - 2;

  // 31.25 kbaud from a 4 MHz clock.
  localparam int DEFAULT_CLKS_PER_BIT = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/midi_baud_tick.sv
// rtl/midi_baud_tick.sv - bit-time tick generator for the MIDI transmitter
//
// Purpose : counts 0..CLKS_PER_BIT-1 while running and emits a one-cycle tick
//           on the last count of every bit time.
// Ports   : clk      - system clock
//           rst      - asynchronous active-high reset
//           restart  - forces the count back to 0 (message acceptance)
//           run      - counter advances only while high, otherwise held at 0
//           tick     - one-cycle pulse at the end of each bit time

module midi_baud_tick #(
  parameter int CLKS_PER_BIT = 128
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic run,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || !run) begin
      cnt <= '0;
    end else if (cnt == LAST_COUNT) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = run && (cnt == LAST_COUNT);

endmodule

// File: rtl/midi_msg_tx.sv
// rtl/midi_msg_tx.sv - MIDI message serialiser (status + 1 or 2 data bytes)
//
// Purpose : accepts a complete MIDI channel message, validates it and sends
//           its bytes back to back as 8N1 frames on a single serial line.
// Ports   : clk, rst             - clock, asynchronous active-high reset
//           msg_valid/msg_ready  - message handshake (ready only in IDLE)
//           status, data1, data2 - message bytes (data2 unused if two_byte)
//           two_byte             - 1: status+data1, 0: status+data1+data2
//           tx                   - serial line, idle high
//           busy                 - a message is being transmitted
//           done                 - one-cycle pulse in the first idle cycle
//           err                  - one-cycle pulse after a rejected message

module midi_msg_tx
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       msg_valid,
  output logic       msg_ready,
  input  logic [7:0] status,
  input  logic [7:0] data1,
  input  logic [7:0] data2,
  input  logic       two_byte,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [2:0] LAST_DATA_BIT = 3'(DATA_BITS - 1);

  tx_state_t  state, state_next;

  logic [7:0] status_q, data1_q, data2_q;
  logic       two_byte_q;
  logic [2:0] bit_idx;
  logic [1:0] byte_idx;
  logic [7:0] cur_byte;

  logic bit_tick;
  logic accept, msg_ok, start_msg, reject_msg;
  logic last_bit, last_byte, msg_end;

  // Handshake and validation. A message is legal when the status byte has
  // its MSB set and every transmitted data byte has its MSB clear.
  assign msg_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign accept     = msg_valid && msg_ready;
  assign msg_ok     = status[7] && !data1[7] && (two_byte || !data2[7]);
  assign start_msg  = accept && msg_ok;
  assign reject_msg = accept && !msg_ok;

  assign last_bit  = (bit_idx == LAST_DATA_BIT);
  assign last_byte = (byte_idx == (two_byte_q ? 2'd1 : 2'd2));
  assign msg_end   = (state == STOP) && bit_tick && last_byte;

  midi_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (start_msg),
    .run     (busy),
    .tick    (bit_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    tx         = 1'b1;
    cur_byte   = status_q;

    case (byte_idx)
      2'd0:    cur_byte = status_q;
      2'd1:    cur_byte = data1_q;
      default: cur_byte = data2_q;
    endcase

    case (state)
      IDLE: begin
        if (start_msg) begin
          state_next = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (bit_tick) begin
          state_next = DATA;
        end
      end
      DATA: begin
        tx = cur_byte[bit_idx];
        if (bit_tick && last_bit) begin
          state_next = STOP;
        end
      end
      STOP: begin
        // The next start bit follows the stop bit directly; only the end of
        // the whole message returns to IDLE.
        if (bit_tick) begin
          state_next = last_byte ? IDLE : START;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q   <= '0;
      data1_q    <= '0;
      data2_q    <= '0;
      two_byte_q <= 1'b0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= msg_end;
      err  <= reject_msg;

      if (start_msg) begin
        status_q   <= status;
        data1_q    <= data1;
        data2_q    <= data2;
        two_byte_q <= two_byte;
        bit_idx    <= '0;
        byte_idx   <= '0;
      end else if (bit_tick) begin
        if (state == DATA) begin
          bit_idx <= last_bit ? 3'd0 : bit_idx + 3'd1;
        end
        if (state == STOP) begin
          byte_idx <= last_byte ? 2'd0 : byte_idx + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_msg_tx.sv
// tb/tb_midi_msg_tx.sv - directed self-checking bench for midi_msg_tx

module tb_midi_msg_tx;

  localparam int C = 128;

  logic       clk = 1'b0;
  logic       rst;
  logic       msg_valid;
  logic       msg_ready;
  logic [7:0] status, data1, data2;
  logic       two_byte;
  logic       tx, busy, done, err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  midi_msg_tx #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .status    (status),
    .data1     (data1),
    .data2     (data2),
    .two_byte  (two_byte),
    .tx        (tx),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected line level of bit i (0 = start, 9 = stop) of an 8N1 frame.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i == 9) return 1'b1;
    return b[i-1];
  endfunction

  task automatic wait_rel(input int t0, input int rel);
    while (cyc < t0 + rel) @(negedge clk);
  endtask

  // Offers a message at a negedge; t0 is the cycle in which it is accepted.
  task automatic drive_msg(input logic [7:0] st, input logic [7:0] d1,
                           input logic [7:0] d2, input logic tb2, output int t0);
    @(negedge clk);
    status    = st;
    data1     = d1;
    data2     = d2;
    two_byte  = tb2;
    msg_valid = 1'b1;
    t0        = cyc;
  endtask

  task automatic test_reset;
    checks++; if (tx !== 1'b1)        begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (msg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", msg_ready); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL reset_err: got %b want 0", err); end
  endtask

  task automatic test_note_on;
    int t0;
    logic [7:0] bytes [3];
    logic exp;
    bytes[0] = 8'h90; bytes[1] = 8'h3C; bytes[2] = 8'h64;
    drive_msg(8'h90, 8'h3C, 8'h64, 1'b0, t0);
    wait_rel(t0, 1);
    msg_valid = 1'b0;
    checks++; if (tx !== 1'b0)        begin errors++; $display("FAIL note_on_latency: tx=%b want 0", tx); end
    checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL note_on_busy: got %b want 1", busy); end
    checks++; if (msg_ready !== 1'b0) begin errors++; $display("FAIL note_on_ready: got %b want 0", msg_ready); end
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 10; i++) begin
        wait_rel(t0, 1 + (10*k + i)*C + C/2);
        exp = frame_bit(bytes[k], i);
        checks++;
        if (tx !== exp) begin errors++; $display("FAIL note_on_bit f%0d b%0d: tx=%b want %b", k, i, tx, exp); end
      end
    end
    wait_rel(t0, 3840);
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL note_on_last_stop: done=%b busy=%b want 0/1", done, busy); end
    wait_rel(t0, 3841);
    checks++; if (done !== 1'b1)      begin errors++; $display("FAIL note_on_done: got %b want 1", done); end
    checks++; if (busy !== 1'b0 || msg_ready !== 1'b1 || tx !== 1'b1) begin
      errors++; $display("FAIL note_on_idle: busy=%b ready=%b tx=%b want 0/1/1", busy, msg_ready, tx); end
    wait_rel(t0, 3842);
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL note_on_done_width: got %b want 0", done); end
  endtask

  task automatic test_program_change;
    int t0;
    logic [7:0] bytes [2];
    logic exp;
    bytes[0] = 8'hC5; bytes[1] = 8'h07;
    drive_msg(8'hC5, 8'h07, 8'hFF, 1'b1, t0);
    wait_rel(t0, 1);
    msg_valid = 1'b0;
    checks++; if (err !== 1'b0 || tx !== 1'b0) begin errors++; $display("FAIL pc_start: err=%b tx=%b want 0/0", err, tx); end
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 10; i++) begin
        wait_rel(t0, 1 + (10*k + i)*C + C/2);
        exp = frame_bit(bytes[k], i);
        checks++;
        if (tx !== exp) begin errors++; $display("FAIL pc_bit f%0d b%0d: tx=%b want %b", k, i, tx, exp); end
      end
    end
    wait_rel(t0, 2560);
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL pc_last_stop: done=%b busy=%b want 0/1", done, busy); end
    wait_rel(t0, 2561);
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL pc_done: done=%b busy=%b want 1/0", done, busy); end
    wait_rel(t0, 2561 + C/2);
    checks++; if (tx !== 1'b1)        begin errors++; $display("FAIL pc_no_third_frame: tx=%b want 1", tx); end
  endtask

  task automatic test_reject;
    int t0;
    logic bad;
    // Status byte without MSB.
    drive_msg(8'h3C, 8'h10, 8'h20, 1'b0, t0);
    wait_rel(t0, 1);
    msg_valid = 1'b0;
    checks++; if (err !== 1'b1)       begin errors++; $display("FAIL rej_status_err: got %b want 1", err); end
    checks++; if (tx !== 1'b1 || msg_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rej_status_idle: tx=%b ready=%b busy=%b done=%b want 1/1/0/0", tx, msg_ready, busy, done); end
    wait_rel(t0, 2);
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL rej_err_width: got %b want 0", err); end
    bad = 1'b0;
    for (int i = 3; i < 3 + 2*C; i++) begin
      wait_rel(t0, i);
      if (tx !== 1'b1 || done !== 1'b0 || msg_ready !== 1'b1) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0)       begin errors++; $display("FAIL rej_quiet: activity=%b want 0", bad); end
    // Data1 with MSB set.
    drive_msg(8'h90, 8'h80, 8'h00, 1'b1, t0);
    wait_rel(t0, 1);
    msg_valid = 1'b0;
    checks++; if (err !== 1'b1 || tx !== 1'b1) begin errors++; $display("FAIL rej_data1: err=%b tx=%b want 1/1", err, tx); end
    // Data2 with MSB set on a three-byte message.
    drive_msg(8'h90, 8'h3C, 8'h80, 1'b0, t0);
    wait_rel(t0, 1);
    msg_valid = 1'b0;
    checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rej_data2: err=%b busy=%b want 1/0", err, busy); end
    wait_rel(t0, 4);
  endtask

  task automatic test_back_to_back;
    int t0, t1;
    logic [7:0] m1 [3];
    logic [7:0] m2 [3];
    logic exp;
    m1[0] = 8'h90; m1[1] = 8'h3C; m1[2] = 8'h64;
    m2[0] = 8'h80; m2[1] = 8'h3C; m2[2] = 8'h00;
    drive_msg(8'h90, 8'h3C, 8'h64, 1'b0, t0);
    wait_rel(t0, 1);
    // msg_valid stays high with the second message offered while busy.
    status = 8'h80; data1 = 8'h3C; data2 = 8'h00;
    checks++; if (tx !== 1'b0)        begin errors++; $display("FAIL b2b_first_start: tx=%b want 0", tx); end
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 10; i++) begin
        wait_rel(t0, 1 + (10*k + i)*C + C/2);
        exp = frame_bit(m1[k], i);
        checks++;
        if (tx !== exp) begin errors++; $display("FAIL b2b_m1_bit f%0d b%0d: tx=%b want %b", k, i, tx, exp); end
      end
    end
    wait_rel(t0, 3840);
    checks++; if (msg_ready !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL b2b_last_stop: ready=%b tx=%b want 0/1", msg_ready, tx); end
    wait_rel(t0, 3841);
    checks++; if (done !== 1'b1 || msg_ready !== 1'b1 || tx !== 1'b1) begin
      errors++; $display("FAIL b2b_gap: done=%b ready=%b tx=%b want 1/1/1", done, msg_ready, tx); end
    t1 = t0 + 3841;
    wait_rel(t1, 1);
    msg_valid = 1'b0;
    checks++; if (tx !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_second_start: tx=%b busy=%b want 0/1", tx, busy); end
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 10; i++) begin
        wait_rel(t1, 1 + (10*k + i)*C + C/2);
        exp = frame_bit(m2[k], i);
        checks++;
        if (tx !== exp) begin errors++; $display("FAIL b2b_m2_bit f%0d b%0d: tx=%b want %b", k, i, tx, exp); end
      end
    end
    wait_rel(t1, 3841);
    checks++; if (done !== 1'b1)      begin errors++; $display("FAIL b2b_m2_done: got %b want 1", done); end
  endtask

  task automatic test_reset_mid_frame;
    int t0;
    logic bad;
    logic [7:0] m [3];
    logic exp;
    m[0] = 8'h80; m[1] = 8'h3C; m[2] = 8'h00;
    drive_msg(8'h90, 8'h3C, 8'h64, 1'b0, t0);
    wait_rel(t0, 1);
    msg_valid = 1'b0;
    // Middle of data bit 0 of the second byte (0x3C -> 0).
    wait_rel(t0, 1 + 11*C + C/2);
    checks++; if (tx !== 1'b0)        begin errors++; $display("FAIL rst_mid_pre: tx=%b want 0", tx); end
    rst = 1'b1;
    #1;
    checks++; if (tx !== 1'b1 || busy !== 1'b0 || msg_ready !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL rst_mid_async: tx=%b busy=%b ready=%b done=%b want 1/0/1/0", tx, busy, msg_ready, done); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 1 + 11*C + C; i < 3900; i++) begin
      wait_rel(t0, i);
      if (done !== 1'b0 || tx !== 1'b1 || msg_ready !== 1'b1) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0)       begin errors++; $display("FAIL rst_mid_discard: activity=%b want 0", bad); end
    drive_msg(8'h80, 8'h3C, 8'h00, 1'b0, t0);
    wait_rel(t0, 1);
    msg_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 10; i++) begin
        wait_rel(t0, 1 + (10*k + i)*C + C/2);
        exp = frame_bit(m[k], i);
        checks++;
        if (tx !== exp) begin errors++; $display("FAIL rst_after_bit f%0d b%0d: tx=%b want %b", k, i, tx, exp); end
      end
    end
    wait_rel(t0, 3841);
    checks++; if (done !== 1'b1)      begin errors++; $display("FAIL rst_after_done: got %b want 1", done); end
  endtask

  initial begin
    rst       = 1'b1;
    msg_valid = 1'b0;
    status    = 8'h00;
    data1     = 8'h00;
    data2     = 8'h00;
    two_byte  = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_note_on;
    test_program_change;
    test_reject;
    test_back_to_back;
    test_reset_mid_frame;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/midi_msg_tx.md
MIDI_MSG_TX -- requirements
Module: midi_msg_tx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, default 128, clk cycles per serial bit (31.25 kbaud at 4 MHz); legal range 2..1023.
REQ-002 SHALL have port: clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: msg_valid  input  1  message offered.
REQ-005 SHALL have port: msg_ready  output  1  block able to accept a message.
REQ-006 SHALL have port: status  input  8  MIDI status byte.
REQ-007 SHALL have port: data1  input  8  first data byte.
REQ-008 SHALL have port: data2  input  8  second data byte; ignored when two_byte=1.
REQ-009 SHALL have port: two_byte  input  1  1 = send status+data1 only; 0 = send all three bytes.
REQ-010 SHALL have port: tx  output  1  serial MIDI line, idle high.
REQ-011 SHALL have port: busy  output  1  high from the cycle after acceptance until the last stop bit ends.
REQ-012 SHALL have port: done  output  1  one-cycle pulse on message completion.
REQ-013 SHALL have port: err  output  1  one-cycle pulse on rejected message.

Function
REQ-014 SHALL accept a message only in a cycle where msg_valid=1 and msg_ready=1, latching status, data1, data2 and two_byte; inputs SHALL be ignored in all other cycles.
REQ-015 SHALL drive msg_ready=1 only in state IDLE.
REQ-016 SHALL validate at acceptance: reject if status[7]=0, data1[7]=1, or (two_byte=0 and data2[7]=1).
REQ-017 On rejection, SHALL pulse err in the following cycle, stay in IDLE with msg_ready=1, keep tx=1, and not pulse done.
REQ-018 On valid acceptance, tx SHALL go low in the next cycle (latency 1).
REQ-019 Each byte SHALL be sent as a 10-bit frame: start 0, bits d0..d7 LSB first, stop 1; every bit held exactly CLKS_PER_BIT cycles.
REQ-020 Bytes SHALL be sent in order status, data1, then data2 (if three-byte), back to back with no idle cycles between frames.
REQ-021 SHALL use FSM states IDLE, START, DATA, STOP: IDLE->START on valid acceptance; START->DATA after one bit time; DATA->STOP after bit 7; STOP->START if bytes remain, else STOP->IDLE.
REQ-022 SHALL use a bit timer counting 0..CLKS_PER_BIT-1 ($clog2 width, wraps to 0), a bit index 0..7, and a byte index 0..2.
REQ-023 In the first IDLE cycle after the last stop bit, SHALL pulse done with msg_ready=1; a message accepted in that cycle starts its start bit in the next cycle, so consecutive messages are separated by one idle-high cycle.
REQ-024 Total tx-active duration SHALL be 30*CLKS_PER_BIT cycles for three-byte messages and 20*CLKS_PER_BIT for two-byte messages.
REQ-025 done and err SHALL never be asserted in the same cycle.

Reset
REQ-026 While rst=1, SHALL force, asynchronously: tx=1, state IDLE, all counters 0, busy=0, done=0, err=0, msg_ready=1.
REQ-027 Reset during a frame SHALL discard the in-flight message with no done pulse; tx SHALL return high immediately.

Structure
REQ-028 SHALL place the FSM state enum, FRAME_BITS=10 and default CLKS_PER_BIT=128 in the shared package midi_pkg.
REQ-029 SHALL instantiate one sub-module, midi_baud_tick, which emits a one-cycle tick every CLKS_PER_BIT cycles and restarts its count on message acceptance.

Verification
REQ-030 Note-on 0x90,0x3C,0x64, two_byte=0, CLKS_PER_BIT=128 -> tx low at T+1; sample mid-bit: 0,0,0,0,0,1,0,0,1,1 for frame 1; 0x3C and 0x64 follow; done at T+3841.
REQ-031 Program change 0xC5,0x07, two_byte=1, data2=0xFF -> two frames only, no error, done at T+2561.
REQ-032 status=0x3C -> err pulse at T+1; tx stays 1; msg_ready stays 1; no done.
REQ-033 msg_valid held high with second message 0x80,0x3C,0x00 -> second start bit falls exactly 2 cycles after the first message's last stop bit ends; msg_valid during busy has no effect.
REQ-034 rst asserted mid-DATA of byte 2 -> tx=1 in the same cycle; no done; after release msg_ready=1 and the next message transmits correctly.
